mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory of the multicycle MIPS core between two requesters.
- Port 0 is the CPU. Its address is the IorD-muxed PC/ALUOut, and MemWrite drives we0.
- Port 1 is the program loader/debug master.
- Each access is registered, memory wait states are counted, and completion is returned through a per-port done pulse. The CPU controller stalls its FSM until done0.

---
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified instruction/data memory between the
// multicycle MIPS core (port 0) and the program loader/debug master (port 1).
// A request is accepted only in IDLE. The winning port's command is latched
// and held on the memory for WAIT cycles. Completion is signalled by a
// one-cycle done pulse on the winning port. All outputs are registered.
module mem_port_arbiter #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    // port 0: CPU
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          done0,
    // port 1: loader / debug master
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          done1,
    // shared read data, valid alongside done after a read
    output logic [DW-1:0] rdata,
    // memory side
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    // The down-counter is 4 bits wide, so WAIT must stay within 1..15.
    generate
        if (WAIT < 1 || WAIT > 15) begin : g_bad_wait
            $error("mem_port_arbiter: WAIT must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    // Port that won the most recent grant; it also owns the access in flight.
    logic          last_gnt_q, last_gnt_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          win;

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_gnt_q  <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_gnt_q  <= last_gnt_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic: round-robin arbitration in IDLE, wait counting in
    // ACCESS, single-cycle completion in RESP. gnt/done default low so they
    // can only ever be one-cycle pulses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_gnt_d  = last_gnt_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        win         = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Under contention the port that did not win last time goes.
                    win        = (req0 && req1) ? ~last_gnt_q : req1;
                    state_d    = ACCESS;
                    busy_d     = 1'b1;
                    mem_en_d   = 1'b1;
                    cnt_d      = CNT_INIT;
                    last_gnt_d = win;
                    if (win) begin
                        gnt1_d      = 1'b1;
                        mem_we_d    = we1;
                        mem_addr_d  = addr1;
                        mem_wdata_d = wdata1;
                    end else begin
                        gnt0_d      = 1'b1;
                        mem_we_d    = we0;
                        mem_addr_d  = addr0;
                        mem_wdata_d = wdata0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = RESP;
                    done0_d  = ~last_gnt_q;
                    done1_d  = last_gnt_q;
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: one WAIT=2 instance for the main
// scenarios and a WAIT=1 instance for the short-latency build.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;

    // WAIT=2 instance signals
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, done0, gnt1, done1;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    // WAIT=1 instance signals
    logic        b_req0, b_we0, b_req1, b_we1;
    logic [31:0] b_addr0, b_wdata0, b_addr1, b_wdata1;
    logic        b_gnt0, b_done0, b_gnt1, b_done1;
    logic [31:0] b_rdata;
    logic        b_mem_en, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_busy;

    int checks = 0;
    int errors = 0;

    // Memory model: a fixed word at 0x40, an address-derived pattern elsewhere.
    assign mem_rdata   = (mem_addr == 32'h40) ? 32'hDEADBEEF : (32'hC0DE0000 | mem_addr);
    assign b_mem_rdata = (b_mem_addr == 32'h40) ? 32'hDEADBEEF : (32'hC0DE0000 | b_mem_addr);

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .done0(done0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT(1)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
        .gnt0(b_gnt0), .done0(b_done0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
        .gnt1(b_gnt1), .done1(b_done1),
        .rdata(b_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        b_req0 = 0; b_we0 = 0; b_addr0 = '0; b_wdata0 = '0;
        b_req1 = 0; b_we1 = 0; b_addr1 = '0; b_wdata1 = '0;
        #1;
        chk("rst_gnt", {gnt0, gnt1, done0, done1}, 4'b0000);
        chk("rst_mem", {mem_en, mem_we, busy}, 3'b000);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single CPU read from 0x40
        req0 = 1; we0 = 0; addr0 = 32'h40;
        tick();                                   // cycle 1
        chk("rd_c1_gnt0", {gnt0, gnt1}, 2'b10);
        chk("rd_c1_mem", {mem_en, mem_we, busy}, 3'b101);
        chk("rd_c1_addr", mem_addr, 32'h40);
        req0 = 0; addr0 = 32'h0;
        tick();                                   // cycle 2
        chk("rd_c2", {gnt0, mem_en, done0, busy}, 4'b0101);
        tick();                                   // cycle 3
        chk("rd_c3", {mem_en, done0, done1, busy}, 4'b0101);
        chk("rd_c3_rdata", rdata, 32'hDEADBEEF);
        tick();                                   // cycle 4
        chk("rd_c4", {done0, busy}, 2'b00);

        // Loader write of 0x12345678 to 0x100
        req1 = 1; we1 = 1; addr1 = 32'h100; wdata1 = 32'h12345678;
        tick();
        chk("wr_c1_gnt", {gnt0, gnt1}, 2'b01);
        chk("wr_c1_mem", {mem_en, mem_we}, 2'b11);
        chk("wr_c1_addr", mem_addr, 32'h100);
        chk("wr_c1_wdata", mem_wdata, 32'h12345678);
        req1 = 0; we1 = 0; addr1 = 32'h0; wdata1 = 32'h0;
        tick();
        chk("wr_c2_mem", {mem_en, mem_we, gnt1}, 3'b110);
        chk("wr_c2_addr", mem_addr, 32'h100);
        chk("wr_c2_wdata", mem_wdata, 32'h12345678);
        tick();
        chk("wr_c3_done", {done0, done1, mem_en, mem_we}, 4'b0100);
        chk("wr_c3_rdata", rdata, 32'hDEADBEEF);
        tick();
        chk("wr_c4_idle", {done1, busy}, 2'b00);

        // Contention from reset: grants at cycles 1,5,9,13 alternating 0,1,0,1
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req0 = 1; addr0 = 32'h40; req1 = 1; addr1 = 32'h200;
        for (int c = 1; c <= 16; c++) begin
            logic eg0, eg1;
            tick();
            eg0 = (c % 4 == 1) && (((c - 1) / 4) % 2 == 0);
            eg1 = (c % 4 == 1) && (((c - 1) / 4) % 2 == 1);
            chk($sformatf("cont_c%0d_gnt", c), {gnt0, gnt1}, {eg0, eg1});
        end
        req0 = 0; req1 = 0;
        tick();
        chk("cont_idle", {busy, gnt0, gnt1}, 3'b000);

        // Back-to-back CPU: gnt0 at 1,5,9, done0 at 3,7,11
        req0 = 1; addr0 = 32'h40;
        for (int c = 1; c <= 12; c++) begin
            logic eg, ed;
            tick();
            eg = (c == 1) || (c == 5) || (c == 9);
            ed = (c == 3) || (c == 7) || (c == 11);
            chk($sformatf("b2b_c%0d", c), {gnt0, done0, gnt1, done1}, {eg, ed, 1'b0, 1'b0});
        end
        req0 = 0;
        tick();

        // Reset in the second ACCESS cycle of a port-1 read
        req1 = 1; we1 = 0; addr1 = 32'h300;
        tick();
        chk("rmid_c1", {gnt1, mem_en}, 2'b11);
        req1 = 0;
        tick();
        chk("rmid_c2", {mem_en, busy}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("rmid_async", {mem_en, mem_we, gnt1, done1, busy}, 5'b00000);
        tick();
        chk("rmid_hold_done1", done1, 1'b0);
        tick();
        chk("rmid_hold2_done1", done1, 1'b0);
        req0 = 1; addr0 = 32'h40; req1 = 1; addr1 = 32'h300;
        #2;
        rst_n = 1'b1;
        tick();
        chk("rmid_first_gnt", {gnt0, gnt1}, 2'b10);
        req0 = 0; req1 = 0;
        tick();
        chk("rmid_post_c2", done1, 1'b0);
        tick();
        chk("rmid_post_c3", {done0, done1}, 2'b10);
        tick();

        // WAIT=1 build: done one cycle after gnt, next gnt 3 cycles after the first
        b_req0 = 1; b_we0 = 0; b_addr0 = 32'h40;
        tick();
        chk("w1_c1", {b_gnt0, b_mem_en, b_busy, b_done0}, 4'b1110);
        tick();
        chk("w1_c2", {b_gnt0, b_mem_en, b_done0, b_busy}, 4'b0011);
        chk("w1_c2_rdata", b_rdata, 32'hDEADBEEF);
        tick();
        chk("w1_c3", {b_gnt0, b_done0, b_busy}, 3'b000);
        tick();
        chk("w1_c4_gnt", {b_gnt0, b_gnt1}, 2'b10);
        b_req0 = 0;
        tick();
        chk("w1_c5_done", b_done0, 1'b1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Mutual exclusion of the pulse pairs on the main instance.
    always @(negedge clk) begin
        if (rst_n && ((gnt0 && gnt1) || (done0 && done1))) begin
            errors++;
            checks++;
            $display("FAIL excl gnt=%b%b done=%b%b exp=no overlap", gnt0, gnt1, done0, done1);
        end
    end

    // Hard time limit in case a scenario stalls.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
